sysid_checker: RTL and testbench
================================

Name: sysid_checker

Overview:
- Avalon-MM master that sits directly downstream of the System ID slave and consumes its two words.
- On a start pulse, or automatically after reset, it reads the ID word (address 0) and then the timestamp word (address 1).
- It captures both words, compares them against expected build values, and reports match, mismatch or timeout.
- Used at bring-up so HPS/FPGA logic can gate operation on a confirmed hardware build.

Parameters:
- EXPECTED_ID, 32'd0: required value at address 0.
- EXPECTED_TS, 32'd1522719104 (0x5AC2D980): required value at address 1.
- READ_LATENCY, 0: fixed cycles from read acceptance to valid readdata; legal range 0..7.
- TIMEOUT_CYCLES, 255: maximum consecutive waitrequest-high cycles per read before abort; range 1..65535.
- AUTO_START, 1: when 1, a check launches on the first clock after reset deasserts.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to run a check; ignored while busy.
- avm_address  out  1  0 = ID word, 1 = timestamp word.
- avm_read  out  1  read strobe, held until accepted.
- avm_waitrequest  in  1  slave stall; tie to 0 for a zero-wait slave.
- avm_readdata  in  32  slave read data.
- id_value  out  32  captured ID word.
- ts_value  out  32  captured timestamp word.
- busy  out  1  check in progress.
- done  out  1  check finished (level).
- match  out  1  both words equal the expected values (valid when done=1).
- timeout  out  1  a read exceeded TIMEOUT_CYCLES (valid when done=1).

Behaviour:
- Reset values: avm_read=0, avm_address=0, id_value=0, ts_value=0, busy=0, done=0, match=0, timeout=0. State=IDLE, with auto-start armed if AUTO_START=1.
- States: IDLE, REQ_ID, LAT_ID, REQ_TS, LAT_TS, DONE.
- IDLE or DONE, on start (or the armed auto-start): go to REQ_ID and clear done, match and timeout. busy=1 in every state except IDLE and DONE.
- REQ_ID: avm_read=1, avm_address=0. The read is accepted in the cycle where avm_read=1 and avm_waitrequest=0.
  - READ_LATENCY=0: capture avm_readdata into id_value in the acceptance cycle, then go to REQ_TS.
  - READ_LATENCY>0: deassert avm_read after acceptance and go to LAT_ID. Capture avm_readdata exactly READ_LATENCY cycles after the acceptance edge, then go to REQ_TS.
- REQ_TS / LAT_TS: identical to REQ_ID / LAT_ID, with avm_address=1 and capture into ts_value; then go to DONE.
- Read count: exactly one accepted read per address per check; avm_read is never asserted in LAT_*, IDLE or DONE.
- Zero-wait slave, latency 0: start in cycle 0 → REQ_ID in cycle 1 → REQ_TS in cycle 2 → done=1 from cycle 3.
- Timeout: a 16-bit counter increments each REQ_* cycle with avm_waitrequest=1 and clears on acceptance and on entry to each REQ_* state. When it reaches TIMEOUT_CYCLES: drop avm_read, set timeout=1, match=0, go to DONE. The captured value for the aborted word is left unchanged.
- DONE: done=1. match=1 iff id_value==EXPECTED_ID and ts_value==EXPECTED_TS and timeout=0. Outputs hold until the next start.
- start while busy is ignored (no restart, no queueing). start in the same cycle as the done transition is ignored; start in DONE re-runs the check.
- Reset mid-operation immediately drops avm_read and returns all outputs to their reset values. With AUTO_START=1, the check re-arms.
- Comparison is a full 32-bit equality; no arithmetic on the captured data.

Test Plan:
- Zero-wait slave returning 0 / 1522719104, AUTO_START=1 → reads at addr 0 then 1 in consecutive cycles; done=1, match=1 in cycle 3 after reset release; id_value=0, ts_value=0x5AC2D980.
- Slave returns 0x5AC2D981 at addr 1 → done=1, match=0, timeout=0, ts_value=0x5AC2D981.
- waitrequest high for 3 cycles on each read, READ_LATENCY=2 → avm_read held 4 cycles per address; data sampled 2 cycles after each accept; match=1; exactly 2 accepted reads.
- TIMEOUT_CYCLES=8, waitrequest stuck high → avm_read drops after 8 stall cycles at addr 0; done=1, timeout=1, match=0, ts_value unchanged.
- start pulsed in REQ_TS → ignored, single completion. Second start in DONE → done clears next cycle and a fresh 2-read sequence runs.
- reset_n asserted while in LAT_ID → avm_read=0, busy=0 and id_value=0 immediately; after release, the auto-start check completes with match=1.

Source files
------------

// File: rtl/sysid_checker.sv
// sysid_checker: Avalon-MM master that reads the System ID words
// (ID, then timestamp), compares them with the expected build values
// and reports match, mismatch or timeout.
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1522719104,
    parameter int          READ_LATENCY   = 0,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        busy,
    output logic        done,
    output logic        match,
    output logic        timeout
);

    typedef enum logic [2:0] {
        IDLE,
        REQ_ID,
        LAT_ID,
        REQ_TS,
        LAT_TS,
        DONE
    } state_t;

    localparam logic [2:0] LAT_LAST =
        3'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_armed;
    logic [15:0] r_cnt;
    logic [2:0]  r_lat;
    logic        r_to;

    logic w_launch;
    logic w_accept;
    logic w_stall;
    logic w_abort;
    logic w_cap_id;
    logic w_cap_ts;
    logic w_lat_inc;

    // State register; auto-start re-arms on every reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_armed <= AUTO_START;
        end else begin
            r_state <= w_next;
            if (w_launch) r_armed <= 1'b0;
        end
    end

    // Next-state decode, bus strobes and status outputs.
    always_comb begin
        w_next      = r_state;
        w_launch    = 1'b0;
        w_accept    = 1'b0;
        w_stall     = 1'b0;
        w_abort     = 1'b0;
        w_cap_id    = 1'b0;
        w_cap_ts    = 1'b0;
        w_lat_inc   = 1'b0;
        avm_read    = 1'b0;
        avm_address = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        unique case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start || r_armed) begin
                    w_launch = 1'b1;
                    w_next   = REQ_ID;
                end
            end
            REQ_ID: begin
                avm_read = 1'b1;
                if (!avm_waitrequest) begin
                    w_accept = 1'b1;
                    if (READ_LATENCY == 0) begin
                        w_cap_id = 1'b1;
                        w_next   = REQ_TS;
                    end else begin
                        w_next = LAT_ID;
                    end
                end else if (r_cnt == TO_LAST) begin
                    w_abort = 1'b1;
                    w_next  = DONE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            LAT_ID: begin
                if (r_lat == LAT_LAST) begin
                    w_cap_id = 1'b1;
                    w_next   = REQ_TS;
                end else begin
                    w_lat_inc = 1'b1;
                end
            end
            REQ_TS: begin
                avm_read    = 1'b1;
                avm_address = 1'b1;
                if (!avm_waitrequest) begin
                    w_accept = 1'b1;
                    if (READ_LATENCY == 0) begin
                        w_cap_ts = 1'b1;
                        w_next   = DONE;
                    end else begin
                        w_next = LAT_TS;
                    end
                end else if (r_cnt == TO_LAST) begin
                    w_abort = 1'b1;
                    w_next  = DONE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            LAT_TS: begin
                if (r_lat == LAT_LAST) begin
                    w_cap_ts = 1'b1;
                    w_next   = DONE;
                end else begin
                    w_lat_inc = 1'b1;
                end
            end
            DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (start) begin
                    w_launch = 1'b1;
                    w_next   = REQ_ID;
                end
            end
            default: begin
                busy   = 1'b0;
                w_next = IDLE;
            end
        endcase
        timeout = r_to;
        match   = done && !r_to &&
                  (id_value == EXPECTED_ID) &&
                  (ts_value == EXPECTED_TS);
    end

    // Stall counter, cleared whenever a REQ state is entered or accepted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_launch || w_accept || w_abort) begin
            r_cnt <= '0;
        end else if (w_stall) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // Read-latency counter, restarted at each acceptance.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_lat <= '0;
        end else if (w_accept) begin
            r_lat <= '0;
        end else if (w_lat_inc) begin
            r_lat <= r_lat + 3'd1;
        end
    end

    // Captured words and timeout flag; an aborted word keeps its old value.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            id_value <= '0;
            ts_value <= '0;
            r_to     <= 1'b0;
        end else begin
            if (w_cap_id) id_value <= avm_readdata;
            if (w_cap_ts) ts_value <= avm_readdata;
            if (w_launch) begin
                r_to <= 1'b0;
            end else if (w_abort) begin
                r_to <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sysid_checker.sv
// tb_sysid_checker: directed scoreboard bench for sysid_checker.
// DUT A: zero latency, short timeout. DUT B: latency 2 with stalls.
module tb_sysid_checker;

    localparam logic [31:0] EXP_TS = 32'h5AC2_D980;
    localparam logic [31:0] B_ID   = 32'h1234_5678;

    typedef struct {
        logic [31:0] id;
        logic [31:0] ts;
        logic        m;
        logic        t;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int vectors = 0;
    int errs    = 0;

    logic clock = 1'b0;
    logic reset_n = 1'b0;

    logic        a_start = 1'b0;
    logic        a_addr, a_read;
    logic        a_wait = 1'b0;
    logic [31:0] a_rdata;
    logic [31:0] a_id, a_ts;
    logic        a_busy, a_done, a_match, a_to;
    logic [31:0] a_id_word = 32'd0;
    logic [31:0] a_ts_word = EXP_TS;

    logic        b_start = 1'b0;
    logic        b_addr, b_read;
    logic        b_wait;
    logic [31:0] b_rdata;
    logic [31:0] b_id, b_ts;
    logic        b_busy, b_done, b_match, b_to;

    int   a_acc = 0, a_rdcyc = 0;
    int   b_acc = 0, b_rdcyc = 0;
    int   b_scnt = 0;
    logic [1:0] b_p1 = 2'b00;
    logic [1:0] b_p2 = 2'b00;

    always #5 clock = ~clock;

    assign a_rdata = a_addr ? a_ts_word : a_id_word;
    assign b_wait  = (b_scnt < 3);
    assign b_rdata = !b_p2[1] ? 32'hDEAD_BEEF :
                     (b_p2[0] ? EXP_TS : B_ID);

    always @(posedge clock) begin
        if (a_read && !a_wait) a_acc <= a_acc + 1;
        if (a_read) a_rdcyc <= a_rdcyc + 1;
        if (b_read && !b_wait) b_acc <= b_acc + 1;
        if (b_read) b_rdcyc <= b_rdcyc + 1;
        if (!b_read || !b_wait) b_scnt <= 0;
        else b_scnt <= b_scnt + 1;
        b_p1 <= {b_read && !b_wait, b_addr};
        b_p2 <= b_p1;
    end

    sysid_checker #(
        .TIMEOUT_CYCLES(8)
    ) u_a (
        .clock(clock), .reset_n(reset_n), .start(a_start),
        .avm_address(a_addr), .avm_read(a_read),
        .avm_waitrequest(a_wait), .avm_readdata(a_rdata),
        .id_value(a_id), .ts_value(a_ts), .busy(a_busy),
        .done(a_done), .match(a_match), .timeout(a_to)
    );

    sysid_checker #(
        .EXPECTED_ID(B_ID),
        .READ_LATENCY(2)
    ) u_b (
        .clock(clock), .reset_n(reset_n), .start(b_start),
        .avm_address(b_addr), .avm_read(b_read),
        .avm_waitrequest(b_wait), .avm_readdata(b_rdata),
        .id_value(b_id), .ts_value(b_ts), .busy(b_busy),
        .done(b_done), .match(b_match), .timeout(b_to)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input int d, input logic [31:0] id,
                        input logic [31:0] ts, input logic m,
                        input logic t);
        exp_t e;
        e.id = id; e.ts = ts; e.m = m; e.t = t;
        if (d == 0) q_a.push_back(e);
        else q_b.push_back(e);
    endtask

    task automatic pop_check(input int d, input string tag);
        exp_t e;
        if ((d == 0 ? q_a.size() : q_b.size()) == 0) begin
            chk({tag, "_queue"}, 32'(d == 0 ? q_a.size() : q_b.size()), 1);
            return;
        end
        e = (d == 0) ? q_a.pop_front() : q_b.pop_front();
        chk({tag, "_id"},    d == 0 ? a_id : b_id, e.id);
        chk({tag, "_ts"},    d == 0 ? a_ts : b_ts, e.ts);
        chk({tag, "_match"}, 32'(d == 0 ? a_match : b_match), 32'(e.m));
        chk({tag, "_to"},    32'(d == 0 ? a_to : b_to), 32'(e.t));
    endtask

    task automatic wait_done(input int d, input string tag);
        for (int n = 0; n < 200; n++) begin
            @(negedge clock);
            if ((d == 0) ? a_done : b_done) break;
        end
        chk({tag, "_done"}, 32'(d == 0 ? a_done : b_done), 1);
        pop_check(d, tag);
    endtask

    task automatic pulse_a();
        @(negedge clock);
        a_start = 1'b1;
        @(negedge clock);
        a_start = 1'b0;
    endtask

    int s_acc, s_rd;

    initial begin
        @(negedge clock);
        chk("rst_read",  32'(a_read),  0);
        chk("rst_addr",  32'(a_addr),  0);
        chk("rst_id",    a_id,         0);
        chk("rst_ts",    a_ts,         0);
        chk("rst_busy",  32'(a_busy),  0);
        chk("rst_done",  32'(a_done),  0);
        chk("rst_match", 32'(a_match), 0);
        chk("rst_to",    32'(a_to),    0);

        push(0, 32'd0, EXP_TS, 1'b1, 1'b0);
        push(1, B_ID, EXP_TS, 1'b1, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("auto_c1_read", 32'(a_read), 1);
        chk("auto_c1_addr", 32'(a_addr), 0);
        chk("auto_c1_busy", 32'(a_busy), 1);
        @(negedge clock);
        chk("auto_c2_read", 32'(a_read), 1);
        chk("auto_c2_addr", 32'(a_addr), 1);
        @(negedge clock);
        chk("auto_c3_done", 32'(a_done), 1);
        pop_check(0, "auto_a");
        chk("auto_a_acc", a_acc, 2);

        wait_done(1, "lat_b");
        chk("lat_b_acc",   b_acc,   2);
        chk("lat_b_rdcyc", b_rdcyc, 8);

        a_ts_word = 32'h5AC2_D981;
        push(0, 32'd0, 32'h5AC2_D981, 1'b0, 1'b0);
        pulse_a();
        chk("bad_done_clr", 32'(a_done), 0);
        wait_done(0, "bad_ts");

        a_wait = 1'b1;
        s_acc = a_acc;
        s_rd  = a_rdcyc;
        push(0, 32'd0, 32'h5AC2_D981, 1'b0, 1'b1);
        pulse_a();
        wait_done(0, "tmo");
        chk("tmo_read",  32'(a_read), 0);
        chk("tmo_rdcyc", a_rdcyc - s_rd, 8);
        chk("tmo_acc",   a_acc - s_acc, 0);
        a_wait = 1'b0;

        a_ts_word = EXP_TS;
        s_acc = a_acc;
        push(0, 32'd0, EXP_TS, 1'b1, 1'b0);
        pulse_a();
        chk("busy_start_req_id", 32'(a_busy), 1);
        @(negedge clock);
        chk("busy_start_addr", 32'(a_addr), 1);
        a_start = 1'b1;
        @(negedge clock);
        a_start = 1'b0;
        chk("busy_start_done", 32'(a_done), 1);
        pop_check(0, "busy_start");
        repeat (3) @(negedge clock);
        chk("busy_start_hold", 32'(a_done), 1);
        chk("busy_start_acc",  a_acc - s_acc, 2);

        s_acc = a_acc;
        push(0, 32'd0, EXP_TS, 1'b1, 1'b0);
        pulse_a();
        chk("rerun_done_clr", 32'(a_done), 0);
        wait_done(0, "rerun");
        chk("rerun_acc", a_acc - s_acc, 2);

        @(negedge clock);
        b_start = 1'b1;
        @(negedge clock);
        b_start = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (b_read && !b_wait) break;
            @(negedge clock);
        end
        chk("mid_accept", 32'(b_read && !b_wait), 1);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("mid_read", 32'(b_read), 0);
        chk("mid_busy", 32'(b_busy), 0);
        chk("mid_id",   b_id,        0);
        chk("mid_a_done", 32'(a_done), 0);
        @(negedge clock);
        push(0, 32'd0, EXP_TS, 1'b1, 1'b0);
        push(1, B_ID, EXP_TS, 1'b1, 1'b0);
        reset_n = 1'b1;
        wait_done(1, "rearm_b");
        wait_done(0, "rearm_a");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errs);
        $finish;
    end

endmodule
